// File: rtl/wptr_full_level.sv
// Write-domain pointer/status block for the dual-clock Gray FIFO: binary/Gray
// write pointer, zero-latency full, fill level, almost-full and sticky overflow.
module wptr_full_level #(
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int A = ADDRSIZE;

  function automatic logic [A:0] bin2gray(input logic [A:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [A:0] wbin_r       = '0;
  logic [A:0] wptr_r       = '0;
  logic [A:0] wlevel_r     = '0;
  logic       wfull_r      = 1'b0;
  logic       walmost_r    = 1'b0;
  logic       woverflow_r  = 1'b0;

  logic       wacc_s;
  logic [A:0] wbinnext_s;
  logic [A:0] wgraynext_s;
  logic [A:0] rbin_s;
  logic [A:0] level_next_s;
  logic       full_next_s;
  logic       almost_next_s;
  logic       ovf_next_s;

  // Next-state pointers, level and flags from the current write state and synced read pointer
  always_comb begin
    wacc_s        = 1'b0;
    wbinnext_s    = wbin_r;
    wgraynext_s   = wptr_r;
    rbin_s        = '0;
    level_next_s  = '0;
    full_next_s   = 1'b0;
    almost_next_s = 1'b0;
    ovf_next_s    = woverflow_r;

    wacc_s        = winc & ~wfull_r;
    wbinnext_s    = wbin_r + {{A{1'b0}}, wacc_s};
    wgraynext_s   = bin2gray(wbinnext_s);
    rbin_s        = gray2bin(wq2_rptr);
    level_next_s  = wbinnext_s - rbin_s;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted
    full_next_s   = (wgraynext_s == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});
    almost_next_s = (level_next_s >= afull_thresh);

    // Set dominates clear so a write rejected in the clearing cycle is not lost
    if (winc & wfull_r) begin
      ovf_next_s = 1'b1;
    end else if (wovf_clr) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = woverflow_r;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_r      <= '0;
      wptr_r      <= '0;
      wlevel_r    <= '0;
      wfull_r     <= 1'b0;
      walmost_r   <= 1'b0;
      woverflow_r <= 1'b0;
    end else begin
      wbin_r      <= wbinnext_s;
      wptr_r      <= wgraynext_s;
      wlevel_r    <= level_next_s;
      wfull_r     <= full_next_s;
      walmost_r   <= almost_next_s;
      woverflow_r <= ovf_next_s;
    end
  end

  assign waddr        = wbin_r[A-1:0];
  assign wptr         = wptr_r;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_r;
  assign wlevel       = wlevel_r;
  assign woverflow    = woverflow_r;

endmodule

// File: doc/wptr_full_level.md
Name: wptr_full_level

Overview:
Write-clock-domain pointer and status block for the dual-clock Gray-pointer FIFO. It is a parametrised successor of the basic write-pointer/full generator. It keeps the same binary/Gray write pointer and registered full flag. It adds:
- a registered write-side fill level
- a programmable almost-full flag
- a sticky overflow flag

It sits between the write-side user logic and the FIFO RAM write port, and feeds wptr to the read-domain 2-FF synchroniser.

Parameters:
ADDRSIZE, 4, log2 of FIFO depth; depth = 2**ADDRSIZE; legal range ADDRSIZE >= 2.

Ports:
wclk  in  1  write clock; all logic on rising edge.
wrst_n  in  1  synchronous, active-low reset.
winc  in  1  write request; accepted only when wfull=0.
wq2_rptr  in  ADDRSIZE+1  read pointer (Gray) already synchronised into wclk.
afull_thresh  in  ADDRSIZE+1  almost-full threshold in entries; quasi-static.
wovf_clr  in  1  clears woverflow.
waddr  out  ADDRSIZE  RAM write address = wbin[ADDRSIZE-1:0].
wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
wfull  out  1  registered full flag.
walmost_full  out  1  registered, level >= afull_thresh.
wlevel  out  ADDRSIZE+1  registered fill level, 0..2**ADDRSIZE.
woverflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (wrst_n=0 at an edge):
  - wbin, wptr, wlevel = 0.
  - wfull, walmost_full, woverflow = 0.
  - All registers also carry initial value 0 for simulation/FPGA power-up.
  - Reset asserted mid-operation discards all state on that edge; no partial update.
- Write accept: wacc = winc & ~wfull.
  - wbinnext = wbin + wacc, modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - Each edge: wbin <= wbinnext, wptr <= wgraynext.
  - waddr is combinational from the wbin register, so data written on edge N uses the waddr presented before edge N.
- Full:
  - wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDRSIZE.
  - wfull asserts on the same edge that accepts the write filling the last entry (zero extra latency).
  - wfull deasserts on the first edge after a changed wq2_rptr is sampled.
- Read pointer conversion:
  - rbin = Gray-to-binary of wq2_rptr: rbin[A] = g[A]; rbin[i] = rbin[i+1] ^ g[i].
  - Purely combinational, no extra register.
- Level:
  - wlevel <= (wbinnext - rbin) mod 2**(A+1).
  - Updates on the same edge as wptr.
  - Value is pessimistic (never under-reports) because the read pointer lags by the synchroniser delay.
- Almost-full:
  - walmost_full <= (level_next >= afull_thresh), unsigned compare, where level_next is the value being loaded into wlevel.
  - afull_thresh = 0 forces walmost_full = 1 from the first edge after reset.
  - afull_thresh > 2**A keeps it at 0.
- Overflow:
  - Set when winc=1 and wfull=1 at an edge.
  - Cleared when wovf_clr=1.
  - Simultaneous set and clear: set wins (woverflow stays 1).
  - A rejected write changes no pointer, level or address.
- Wrap-around: pointers wrap naturally at 2**(A+1); the extra MSB distinguishes full from empty.
- Simultaneous write and read-pointer advance: both take effect in the same level/full computation.

Test Plan:
- Reset, ADDRSIZE=4: hold wrst_n=0 two edges with winc=1 -> waddr=0, wptr=0, wlevel=0, all flags 0.
- Fill from empty: wq2_rptr=0, 16 consecutive winc -> waddr 0..15 then 0. After the 16th edge: wptr=5'b11000, wlevel=16, wfull=1 on that same edge. The 15th edge leaves wfull=0.
- Overflow: while full, pulse winc 1 cycle -> woverflow=1 next edge, wptr unchanged. Then wovf_clr=1 with winc=1 -> woverflow remains 1. Then wovf_clr=1 with winc=0 -> woverflow=0.
- Almost-full: afull_thresh=12 from empty -> walmost_full rises on the edge where wlevel becomes 12. With afull_thresh=0 -> walmost_full=1 on the first edge after reset.
- Drain and wrap: after fill, drive wq2_rptr=5'b11000 -> next edge wfull=0, wlevel=0. Then 16 more writes -> wbin wraps to 0, wptr=0, wfull=1, wlevel=16.
- Reset mid-operation: wlevel=9, woverflow=1, assert wrst_n=0 for one edge -> all outputs 0 next edge. The first write afterwards goes to waddr 0.
